// File: rtl/button_pkg.sv
// Shared types and default timing for the button front end: FSM state encoding
// and the default debounce/auto-repeat cycle counts.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W           = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 1000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 250000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button front end: synchronise, debounce, and emit one clk_en pulse per press.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module button_pulse_gen
  import button_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_input,
  input  logic rst,
  input  logic btn_in,
  output logic clk_en,
  output logic btn_level
);

  localparam logic PARAMS_OK =
    (DEBOUNCE_CYCLES >= 2) &&
    (64'(DEBOUNCE_CYCLES) < (64'd1 << CNT_W)) &&
    (64'(REPEAT_DELAY)    < (64'd1 << CNT_W)) &&
    (64'(REPEAT_PERIOD)   < (64'd1 << CNT_W));

  if (!PARAMS_OK) begin : g_bad_params
    $error("button_pulse_gen: cycle parameters out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

  sync_2ff u_sync (
    .clk (clk_input),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              clk_en_d, clk_en_q;
  logic              btn_level_d, btn_level_q;

  logic [CNT_W-1:0]  cnt_inc;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef BUTTON_AUTOREPEAT_EN
  logic [CNT_W-1:0]  rpt_cnt_d, rpt_cnt_q;
  logic              rpt_first_d, rpt_first_q;
  logic [CNT_W-1:0]  rpt_term;
  assign rpt_term = rpt_first_q ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Debounce FSM; a bounce always beats a simultaneous terminal count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_en_d    = 1'b0;
    btn_level_d = btn_level_q;

    case (state_q)
      IDLE: begin
        btn_level_d = 1'b0;
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TERM) begin
          state_d     = HELD;
          cnt_d       = '0;
          clk_en_d    = 1'b1;
          btn_level_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        btn_level_d = 1'b1;
        if (!btn_s) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TERM) begin
          state_d     = IDLE;
          cnt_d       = '0;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        btn_level_d = 1'b0;
      end
    endcase

`ifdef BUTTON_AUTOREPEAT_EN
    // Repeat timer runs only while the button stays in HELD; any exit re-arms the long delay.
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    if (state_q == HELD && btn_s) begin
      rpt_first_d = rpt_first_q;
      if (rpt_cnt_q == rpt_term) begin
        clk_en_d    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = (rpt_cnt_q == {CNT_W{1'b1}}) ? rpt_cnt_q : rpt_cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_input) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      btn_level_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      btn_level_q <= btn_level_d;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign clk_en    = clk_en_q;
  assign btn_level = btn_level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen: expected pulse cycles are queued when the
// button is driven and matched against every observed clk_en pulse.
module tb_button_pulse_gen;
  import button_pkg::*;

  localparam int unsigned T_CNT_W  = 8;
  localparam int unsigned T_DEB    = 4;
  localparam int unsigned T_DELAY  = 10;
  localparam int unsigned T_PERIOD = 3;
  localparam int          PRESS_LAT = int'(T_DEB) + 3;   // drive cycle -> pulse cycle

  logic clk_input;
  logic rst;
  logic btn_in;
  logic clk_en;
  logic btn_level;

  button_pulse_gen #(
    .CNT_W           (T_CNT_W),
    .DEBOUNCE_CYCLES (T_DEB),
    .REPEAT_DELAY    (T_DELAY),
    .REPEAT_PERIOD   (T_PERIOD)
  ) dut (
    .clk_input (clk_input),
    .rst       (rst),
    .btn_in    (btn_in),
    .clk_en    (clk_en),
    .btn_level (btn_level)
  );

  initial clk_input = 1'b0;
  always #5 clk_input = ~clk_input;

  int cyc = 0;
  always @(posedge clk_input) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int exp_q[$];
  logic prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_input);
  endtask

  // Pulse monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk_input) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("missed_pulse", 32'(cyc), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (clk_en === 1'b1) begin
        check("pulse_pending", 32'(exp_q.size() > 0), 32'd1);
        check("no_back_to_back", 32'(prev_en), 32'd0);
        if (exp_q.size() > 0) check("pulse_cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
      prev_en = clk_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  int c, r, b, g, p, q;

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk_input);
    check("reset_clk_en", 32'(clk_en), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    check("reset_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b0;

    // Idle with button released
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_input);
      check("idle_clk_en", 32'(clk_en), 32'd0);
      check("idle_level", 32'(btn_level), 32'd0);
    end

    // Clean press, long hold (auto-repeat window), release
    c = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c + PRESS_LAT);
    wait_until(c + PRESS_LAT - 1);
    check("press_level_early", 32'(btn_level), 32'd0);
    check("press_en_early", 32'(clk_en), 32'd0);
    wait_until(c + PRESS_LAT);
    check("press_level", 32'(btn_level), 32'd1);
    check("press_en", 32'(clk_en), 32'd1);
    wait_until(c + PRESS_LAT + 1);
    check("press_en_drop", 32'(clk_en), 32'd0);
    r = c + PRESS_LAT + 30;
`ifdef BUTTON_AUTOREPEAT_EN
    // Last edge at which the FSM still sees the button held is r+2.
    for (int t = c + PRESS_LAT + int'(T_DELAY); t <= r + 2; t += int'(T_PERIOD))
      exp_q.push_back(t);
`endif
    wait_until(r);
    btn_in = 1'b0;
    wait_until(r + PRESS_LAT - 1);
    check("release_level_early", 32'(btn_level), 32'd1);
    wait_until(r + PRESS_LAT);
    check("release_level", 32'(btn_level), 32'd0);
    wait_until(r + 20);
    check("clean_queue_empty", 32'(exp_q.size()), 32'd0);

    // Bounce 1,0,1,0 then hold 1
    b = cyc;
    btn_in = 1'b1; @(negedge clk_input);
    btn_in = 1'b0; @(negedge clk_input);
    btn_in = 1'b1; @(negedge clk_input);
    btn_in = 1'b0; @(negedge clk_input);
    btn_in = 1'b1;
    exp_q.push_back(b + 4 + PRESS_LAT);
    wait_until(b + 4 + PRESS_LAT - 1);
    check("bounce_level_early", 32'(btn_level), 32'd0);
    wait_until(b + 4 + PRESS_LAT);
    check("bounce_level", 32'(btn_level), 32'd1);
    wait_until(b + 13);
    btn_in = 1'b0;
    wait_until(b + 13 + PRESS_LAT);
    check("bounce_release", 32'(btn_level), 32'd0);
    wait_until(b + 25);
    check("bounce_queue_empty", 32'(exp_q.size()), 32'd0);

    // Short glitches while idle: 1 cycle, then 3 cycles
    g = cyc;
    btn_in = 1'b1;
    wait_until(g + 1); btn_in = 1'b0;
    wait_until(g + 5); btn_in = 1'b1;
    wait_until(g + 8); btn_in = 1'b0;
    for (int i = 9; i <= 20; i++) begin
      wait_until(g + i);
      check("idle_glitch_level", 32'(btn_level), 32'd0);
    end

    // 3-cycle release glitch while held
    p = cyc;
    btn_in = 1'b1;
    exp_q.push_back(p + PRESS_LAT);
    wait_until(p + 9);  btn_in = 1'b0;
    wait_until(p + 12); btn_in = 1'b1;
    for (int i = 13; i <= 18; i++) begin
      wait_until(p + i);
      check("held_glitch_level", 32'(btn_level), 32'd1);
    end
    btn_in = 1'b0;
    wait_until(p + 18 + PRESS_LAT);
    check("held_glitch_release", 32'(btn_level), 32'd0);
    wait_until(p + 30);
    check("held_glitch_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while held; button stays pressed through reset
    q = cyc;
    btn_in = 1'b1;
    exp_q.push_back(q + PRESS_LAT);
    wait_until(q + 9);
    rst = 1'b1;
    wait_until(q + 10);
    check("midrst_clk_en", 32'(clk_en), 32'd0);
    check("midrst_level", 32'(btn_level), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    exp_q.push_back(q + 10 + PRESS_LAT);
    wait_until(q + 10 + PRESS_LAT - 1);
    check("postrst_level_early", 32'(btn_level), 32'd0);
    wait_until(q + 10 + PRESS_LAT);
    check("postrst_level", 32'(btn_level), 32'd1);
    wait_until(q + 20);
    btn_in = 1'b0;
    wait_until(q + 35);
    check("postrst_release", 32'(btn_level), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
